// File: rtl/pipe_feed_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_feed_ctrl
//
// Issue controller between an upstream 32-bit FIFO and one CPU pipeline stage.
// Pops upstream words, forwards the first KEEP words of every FRAME_LEN-word
// frame to the CPU (din/valid) and pops-and-drops the rest. Keep-slot pops are
// credit-gated so the downstream FIFO (DN_DEPTH deep) can never overflow.
//
// Optional feature: define PIPE_FEED_STATS_EN to build the issued/dropped
// word counters; when undefined both counter outputs are tied to 0.
//
// Ports:
//   bus_clk      in   1   clock, rising edge
//   rst          in   1   synchronous active-high reset
//   enable       in   1   level, allows issuing
//   flush        in   1   pulse, discard upstream contents
//   up_empty     in   1   upstream FIFO empty
//   up_rd_en     out  1   upstream FIFO read strobe
//   up_dout      in   32  upstream FIFO data, valid the cycle after up_rd_en
//   cpu_din      out  16  data to CPU (up_dout[15:0])
//   cpu_valid    out  1   CPU input valid, one cycle per forwarded word
//   dn_pop       in   1   downstream FIFO read accepted, returns one credit
//   credits      out  CW  current credit count
//   busy         out  1   high whenever the FSM is not IDLE
//   issued_cnt   out  32  forwarded-word counter (stats build only)
//   dropped_cnt  out  32  dropped-word counter (stats build only)
// -----------------------------------------------------------------------------
module pipe_feed_ctrl #(
    parameter int FRAME_LEN = 4,
    parameter int KEEP      = 1,
    parameter int DN_DEPTH  = 512,
    parameter int CW        = 10
) (
    input  logic          bus_clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          flush,
    input  logic          up_empty,
    output logic          up_rd_en,
    input  logic [31:0]   up_dout,
    output logic [15:0]   cpu_din,
    output logic          cpu_valid,
    input  logic          dn_pop,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic [31:0]   issued_cnt,
    output logic [31:0]   dropped_cnt
);

    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [FW-1:0] LAST_IDX   = FW'(FRAME_LEN - 1);
    localparam logic [FW:0]   KEEP_V     = (FW + 1)'(KEEP);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DN_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [FW-1:0] r_frame_idx;
    logic [CW-1:0] r_credits;
    logic          r_valid;
    logic [15:0]   r_din;
    logic          r_pop_prev;

    logic          w_keep_slot;
    logic          w_credits_avail;
    logic          w_rd_run;
    logic          w_rd_flush;
    logic          w_keep_pop;
    logic          w_unused_dout;

    assign w_unused_dout = &{1'b0, up_dout[31:16]};

    assign w_keep_slot = ({1'b0, r_frame_idx} < KEEP_V);

    // r_valid is exactly "a keep-slot pop happened last cycle", so it doubles
    // as the pending term: one credit is held back for that word.
    assign w_credits_avail = (r_credits > {{(CW-1){1'b0}}, r_valid});

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_run    = 1'b0;
        w_rd_flush  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush)       w_state_nxt = S_FLUSH;
                else if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A disable or flush request stops popping in that same
                // cycle, so no word is popped that the next state would orphan.
                if (flush)        w_state_nxt = S_FLUSH;
                else if (!enable) w_state_nxt = S_IDLE;
                else              w_rd_run = !up_empty && (!w_keep_slot || w_credits_avail);
            end
            S_FLUSH: begin
                w_rd_flush = !up_empty;
                // Wait one quiet cycle so the last popped word has left the
                // FIFO output before declaring the flush done.
                if (up_empty && !r_pop_prev) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_keep_pop = w_rd_run && w_keep_slot;

    // Gating with rst keeps the read strobe quiet during the reset cycle,
    // so reset never steals a word from the upstream FIFO.
    assign up_rd_en  = (w_rd_run || w_rd_flush) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign credits   = r_credits;
    assign cpu_valid = r_valid;

    // The upstream FIFO registers its output, so the popped word is on
    // up_dout exactly in the valid cycle; afterwards the last word is held.
    assign cpu_din = r_valid ? up_dout[15:0] : r_din;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame_idx <= '0;
            r_credits   <= CREDIT_MAX;
            r_valid     <= 1'b0;
            r_din       <= '0;
            r_pop_prev  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_keep_pop;
            r_pop_prev <= up_rd_en;
            if (r_valid) r_din <= up_dout[15:0];

            if (r_state != S_FLUSH && w_state_nxt == S_FLUSH)
                r_frame_idx <= '0;
            else if (w_rd_run)
                r_frame_idx <= (r_frame_idx == LAST_IDX) ? '0 : r_frame_idx + FW'(1);

            // A return arriving with a keep pop cancels out; a lone return
            // while already full is ignored.
            if (w_keep_pop && !dn_pop)
                r_credits <= r_credits - CW'(1);
            else if (!w_keep_pop && dn_pop && r_credits != CREDIT_MAX)
                r_credits <= r_credits + CW'(1);
        end
    end

`ifdef PIPE_FEED_STATS_EN
    logic [31:0] r_issued;
    logic [31:0] r_dropped;

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_issued  <= '0;
            r_dropped <= '0;
        end else begin
            if (r_valid)                  r_issued  <= r_issued + 32'd1;
            if (w_rd_run && !w_keep_slot) r_dropped <= r_dropped + 32'd1;
        end
    end

    assign issued_cnt  = r_issued;
    assign dropped_cnt = r_dropped;
`else
    assign issued_cnt  = '0;
    assign dropped_cnt = '0;
`endif

endmodule
